// File: rtl/modulo_arbitro_bandeja_rolhas.sv
// Cork-tray count arbiter: latches consumption, manual-load and auto-refill
// requests, grants one per GRANT cycle and applies the bounded update.
// Optional feature macro: ARBITRO_ROUND_ROBIN_EN (rotating priority instead
// of fixed cons > man > refill).
module modulo_arbitro_bandeja_rolhas #(
  parameter int WIDTH       = 7,
  parameter int MAX_ROLHAS  = 99,
  parameter int MIN_ROLHAS  = 5,
  parameter int REFILL_QTY  = 20,
  parameter int REFILL_HOLD = 8
) (
  input  logic             clk,
  input  logic             Nclr,
  input  logic             enable,
  input  logic             req_cons,
  input  logic             req_man,
  input  logic [WIDTH-1:0] man_qty,
  output logic [WIDTH-1:0] count,
  output logic             gnt_cons,
  output logic             gnt_man,
  output logic             gnt_refill,
  output logic             busy,
  output logic             ro,
  output logic             min_r,
  output logic             sat,
  output logic             err_under,
  output logic             ovr
);

  localparam int HW = (REFILL_HOLD < 1) ? 1 : $clog2(REFILL_HOLD + 1);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_ROLHAS);
  localparam logic [WIDTH:0]   REF_EXT = (WIDTH+1)'(REFILL_QTY);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_ROLHAS);
  localparam logic [HW-1:0]    HOLD_W  = HW'(REFILL_HOLD);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  typedef enum logic [1:0] {WIN_CONS, WIN_MAN, WIN_REF} win_t;

  state_t           state_q, state_d;
  win_t             winner_q, winner_d, pick;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] manQty_q, manQty_d;
  logic [HW-1:0]    holdCnt_q, holdCnt_d;
  logic             pCons_q, pCons_d, pMan_q, pMan_d, pRef_q, pRef_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH:0]   manSum, refSum;
  logic             inGrant, consOk, manOk;
  logic             clrCons, clrMan, clrRef;
`ifdef ARBITRO_ROUND_ROBIN_EN
  win_t             lastWin_q, lastWin_d;
`endif

  // Status flags and grant/pulse outputs decoded from the registered state.
  always_comb begin
    manSum     = {1'b0, count_q} + {1'b0, manQty_q};
    refSum     = {1'b0, count_q} + REF_EXT;
    inGrant    = (state_q == GRANT);
    consOk     = (count_q != '0);
    manOk      = (manSum <= MAX_EXT);
    clrCons    = inGrant && (winner_q == WIN_CONS);
    clrMan     = inGrant && (winner_q == WIN_MAN);
    clrRef     = inGrant && (winner_q == WIN_REF);
    gnt_cons   = clrCons && consOk;
    err_under  = clrCons && !consOk;
    gnt_man    = clrMan && manOk;
    sat        = clrMan && !manOk;
    gnt_refill = clrRef;
    busy       = (state_q != IDLE);
    ro         = (count_q == '0);
    min_r      = (count_q <= MIN_W);
    count      = count_q;
    ovr        = ovr_q;
  end

  // Winner selection among the pending bits, fixed or rotating priority.
  always_comb begin
    pick = WIN_CONS;
`ifdef ARBITRO_ROUND_ROBIN_EN
    case (lastWin_q)
      WIN_CONS: begin
        if (pMan_q)       pick = WIN_MAN;
        else if (pRef_q)  pick = WIN_REF;
        else              pick = WIN_CONS;
      end
      WIN_MAN: begin
        if (pRef_q)       pick = WIN_REF;
        else if (pCons_q) pick = WIN_CONS;
        else              pick = WIN_MAN;
      end
      default: begin
        if (pCons_q)      pick = WIN_CONS;
        else if (pMan_q)  pick = WIN_MAN;
        else              pick = WIN_REF;
      end
    endcase
`else
    if (pCons_q)      pick = WIN_CONS;
    else if (pMan_q)  pick = WIN_MAN;
    else              pick = WIN_REF;
`endif
  end

  // Next-state logic: FSM, count update, pending bits and overrun flag.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    count_d   = count_q;
    holdCnt_d = holdCnt_q;
    manQty_d  = manQty_q;
`ifdef ARBITRO_ROUND_ROBIN_EN
    lastWin_d = lastWin_q;
`endif

    case (state_q)
      IDLE: begin
        if (enable && (pCons_q || pMan_q || pRef_q)) begin
          state_d  = GRANT;
          winner_d = pick;
        end
      end
      GRANT: begin
`ifdef ARBITRO_ROUND_ROBIN_EN
        lastWin_d = winner_q;
`endif
        case (winner_q)
          WIN_CONS: if (consOk) count_d = count_q - WIDTH'(1);
          WIN_MAN:  if (manOk) count_d = manSum[WIDTH-1:0];
          default:  count_d = (refSum > MAX_EXT) ? MAX_EXT[WIDTH-1:0]
                                                 : refSum[WIDTH-1:0];
        endcase
        if (winner_q == WIN_REF) begin
          state_d   = HOLD;
          holdCnt_d = HOLD_W;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (holdCnt_q <= HW'(1)) begin
          state_d   = IDLE;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d   = IDLE;
      holdCnt_d = '0;
    end

    pCons_d = (pCons_q && !clrCons) || req_cons;
    pMan_d  = (pMan_q && !clrMan) || req_man;
    pRef_d  = (pRef_q && !clrRef) || (min_r && (holdCnt_q == '0) && !pRef_q);
    if (req_man && (!pMan_q || clrMan)) manQty_d = man_qty;
    ovr_d = ovr_q || (req_cons && pCons_q && !clrCons)
                  || (req_man && pMan_q && !clrMan);

    if (!enable) begin
      pCons_d = 1'b0;
      pMan_d  = 1'b0;
      pRef_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      state_q   <= IDLE;
      winner_q  <= WIN_CONS;
      count_q   <= '0;
      manQty_q  <= '0;
      holdCnt_q <= '0;
      pCons_q   <= 1'b0;
      pMan_q    <= 1'b0;
      pRef_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
      lastWin_q <= WIN_REF;
`endif
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      count_q   <= count_d;
      manQty_q  <= manQty_d;
      holdCnt_q <= holdCnt_d;
      pCons_q   <= pCons_d;
      pMan_q    <= pMan_d;
      pRef_q    <= pRef_d;
      ovr_q     <= ovr_d;
`ifdef ARBITRO_ROUND_ROBIN_EN
      lastWin_q <= lastWin_d;
`endif
    end
  end

endmodule

// File: tb/tb_modulo_arbitro_bandeja_rolhas.sv
// Directed testbench for the cork-tray arbiter with hand-computed expectations.
module tb_modulo_arbitro_bandeja_rolhas;

  logic       clk = 1'b0;
  logic       Nclr, enable, req_cons, req_man;
  logic [6:0] man_qty, count;
  logic       gnt_cons, gnt_man, gnt_refill, busy, ro, min_r, sat, err_under, ovr;

  int checks   = 0;
  int failures = 0;
  int refCount;

  modulo_arbitro_bandeja_rolhas dut (
    .clk(clk), .Nclr(Nclr), .enable(enable), .req_cons(req_cons),
    .req_man(req_man), .man_qty(man_qty), .count(count),
    .gnt_cons(gnt_cons), .gnt_man(gnt_man), .gnt_refill(gnt_refill),
    .busy(busy), .ro(ro), .min_r(min_r), .sat(sat),
    .err_under(err_under), .ovr(ovr)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One immediate-assertion comparison with failure bookkeeping.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive request inputs for exactly one clock cycle.
  task automatic applyStimulus(input logic c, input logic m, input logic [6:0] q);
    req_cons = c;
    req_man  = m;
    man_qty  = q;
    step();
    req_cons = 1'b0;
    req_man  = 1'b0;
  endtask

`ifdef ARBITRO_ROUND_ROBIN_EN
  int order[4];
  int found;
`endif

  // Linear directed sequence.
  initial begin
    Nclr = 1'b0; enable = 1'b1; req_cons = 1'b0; req_man = 1'b0; man_qty = '0;
    #12;
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_ro", int'(ro), 1);
    checkOutput("reset_min_r", int'(min_r), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_gnt", int'({gnt_cons, gnt_man, gnt_refill}), 0);
    checkOutput("reset_ovr", int'(ovr), 0);
    Nclr = 1'b1;

    // Auto refill from empty, then no second refill.
    step();
    checkOutput("refill_pending_busy", int'(busy), 0);
    step();
    checkOutput("refill_gnt", int'(gnt_refill), 1);
    checkOutput("refill_busy", int'(busy), 1);
    step();
    checkOutput("refill_count", int'(count), 20);
    checkOutput("refill_min_r", int'(min_r), 0);
    checkOutput("refill_gnt_drop", int'(gnt_refill), 0);
    refCount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt_refill) refCount++;
    end
    checkOutput("refill_no_repeat", refCount, 0);
    checkOutput("refill_idle_busy", int'(busy), 0);

    // Simultaneous consumption and manual load.
    applyStimulus(1'b1, 1'b1, 7'd10);
    step();
    checkOutput("dual_gnt_cons", int'(gnt_cons), 1);
    checkOutput("dual_gnt_man_wait", int'(gnt_man), 0);
    step();
    checkOutput("dual_count_cons", int'(count), 19);
    step();
    checkOutput("dual_gnt_man", int'(gnt_man), 1);
    step();
    checkOutput("dual_count_man", int'(count), 29);
    checkOutput("dual_busy", int'(busy), 0);

    // Saturation boundary around MAX_ROLHAS.
    applyStimulus(1'b0, 1'b1, 7'd66);
    step();
    step();
    checkOutput("load_95", int'(count), 95);
    applyStimulus(1'b0, 1'b1, 7'd5);
    step();
    checkOutput("sat_pulse", int'(sat), 1);
    checkOutput("sat_no_gnt", int'(gnt_man), 0);
    step();
    checkOutput("sat_count", int'(count), 95);
    checkOutput("sat_drop", int'(sat), 0);
    applyStimulus(1'b0, 1'b1, 7'd4);
    step();
    checkOutput("load4_gnt", int'(gnt_man), 1);
    step();
    checkOutput("load_99", int'(count), 99);

    // Zero-quantity manual load is granted without change.
    applyStimulus(1'b0, 1'b1, 7'd0);
    step();
    checkOutput("qty0_gnt", int'(gnt_man), 1);
    step();
    checkOutput("qty0_count", int'(count), 99);

    // Requests while disabled are dropped.
    enable = 1'b0;
    applyStimulus(1'b1, 1'b0, 7'd0);
    step();
    enable = 1'b1;
    step(); step(); step();
    checkOutput("disabled_count", int'(count), 99);
    checkOutput("disabled_busy", int'(busy), 0);

    // Repeat consumption request while pending: overrun, single decrement.
    req_cons = 1'b1;
    step();
    step();
    checkOutput("ovr_set", int'(ovr), 1);
    checkOutput("ovr_gnt", int'(gnt_cons), 1);
    req_cons = 1'b0;
    step();
    checkOutput("ovr_count", int'(count), 98);
    step(); step(); step();
    checkOutput("ovr_single_dec", int'(count), 98);
    checkOutput("ovr_sticky", int'(ovr), 1);

    // Reset clears overrun; consumption at zero gives err_under.
    Nclr = 1'b0;
    req_cons = 1'b1;
    #2;
    checkOutput("reset2_ovr", int'(ovr), 0);
    checkOutput("reset2_count", int'(count), 0);
    Nclr = 1'b1;
    step();
    req_cons = 1'b0;
    step();
    checkOutput("under_pulse", int'(err_under), 1);
    checkOutput("under_no_gnt", int'(gnt_cons), 0);
    step();
    checkOutput("under_count", int'(count), 0);
    checkOutput("under_ro", int'(ro), 1);
    checkOutput("under_drop", int'(err_under), 0);
    step();
    checkOutput("under_refill_gnt", int'(gnt_refill), 1);
    step();
    checkOutput("under_refill_count", int'(count), 20);

`ifdef ARBITRO_ROUND_ROBIN_EN
    // Rotating priority with all three requesters pending continuously.
    Nclr = 1'b0;
    #2;
    Nclr = 1'b1;
    req_cons = 1'b1; req_man = 1'b1; man_qty = 7'd1;
    found = 0;
    for (int i = 0; i < 60 && found < 4; i++) begin
      step();
      if (gnt_cons || err_under) begin order[found] = 0; found++; end
      else if (gnt_man || sat) begin order[found] = 1; found++; end
      else if (gnt_refill) begin order[found] = 2; found++; end
    end
    req_cons = 1'b0; req_man = 1'b0;
    checkOutput("rr_found", found, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < found) checkOutput("rr_order", order[i], i % 3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
